// File: rtl/nibbler_arb_pkg.sv
// Shared types and constants for the nibbler data-RAM arbiter.
// Holds the FSM state enum, requester IDs and default RAM widths.
package nibbler_arb_pkg;

  localparam int NIB_ADDR_W = 12;
  localparam int NIB_DATA_W = 4;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker; owns rr_last (reset to HOST).
// Ports: clk, reset, req[1:0] (bit0 CPU, bit1 HOST), update, grant.
module arb_rr2
  import nibbler_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant
);

  logic rr_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= REQ_HOST;
    end else if (update) begin
      rr_last <= grant;
    end
  end

  // On a tie the requester that did not go last wins.
  always_comb begin
    grant = REQ_CPU;
    unique case (req)
      2'b10:   grant = REQ_HOST;
      2'b11:   grant = ~rr_last;
      default: grant = REQ_CPU;
    endcase
  end

endmodule

// File: rtl/nibbler_ram_arbiter.sv
// Arbitrates the single-port 4Kx4 data RAM between CPU and host loader.
// Ports: cpu_* / host_* request sides, ram_* array side, cpu_stall.
// Optional NIBBLER_ARB_STATS_EN adds stats_clr, cpu_wait_cnt, host_acc_cnt.
module nibbler_ram_arbiter
  import nibbler_arb_pkg::*;
#(
  parameter int ADDR_W  = NIB_ADDR_W,
  parameter int DATA_W  = NIB_DATA_W,
  parameter int ACC_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
`ifdef NIBBLER_ARB_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       cpu_wait_cnt,
  output logic [15:0]       host_acc_cnt,
`endif
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_e        state;
  arb_state_e        state_nxt;
  logic [3:0]        cnt;
  logic              own_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant;
  logic              take;
  logic              last_cyc;

  assign take     = (state == IDLE) & (cpu_req | host_req);
  assign last_cyc = (cnt == 4'(ACC_CYC - 1));

  arb_rr2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req    ({host_req, cpu_req}),
    .update (take),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = SERVE;
      SERVE:   if (last_cyc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_cs    = (state == SERVE);
    ram_we    = (state == SERVE) & we_q;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    cpu_ack   = (state == DONE) & (own_q == REQ_CPU);
    host_ack  = (state == DONE) & (own_q == REQ_HOST);
    cpu_stall = cpu_req & ~cpu_ack;
  end

  // Holding registers: frozen for the whole access so the
  // non-owner's bus changes cannot reach the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      own_q   <= REQ_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      own_q <= grant;
      if (grant == REQ_HOST) begin
        we_q    <= host_we;
        addr_q  <= host_addr;
        wdata_q <= host_wdata;
      end else begin
        we_q    <= cpu_we;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (take) begin
      cnt <= '0;
    end else if (state == SERVE && !last_cyc) begin
      cnt <= cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdata  <= '0;
      host_rdata <= '0;
    end else if (state == SERVE && last_cyc && !we_q) begin
      if (own_q == REQ_CPU) begin
        cpu_rdata <= ram_rdata;
      end else begin
        host_rdata <= ram_rdata;
      end
    end
  end

`ifdef NIBBLER_ARB_STATS_EN
  logic cpu_wait;

  // CPU waits while idle-arbitrating or while the host owns the RAM.
  assign cpu_wait = cpu_req & ~cpu_ack &
                    ((state == IDLE) | (own_q == REQ_HOST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_wait_cnt <= '0;
      host_acc_cnt <= '0;
    end else if (stats_clr) begin
      cpu_wait_cnt <= '0;
      host_acc_cnt <= '0;
    end else begin
      if (cpu_wait && cpu_wait_cnt != 16'hFFFF) begin
        cpu_wait_cnt <= cpu_wait_cnt + 16'd1;
      end
      if (host_ack && host_acc_cnt != 16'hFFFF) begin
        host_acc_cnt <= host_acc_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nibbler_ram_arbiter.sv
// Directed bench for nibbler_ram_arbiter (ACC_CYC 1 and 3 instances).
// Vector table plus hand sequences for fairness, hold and reset.
module tb_nibbler_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [3:0]  cpu_wdata = '0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [11:0] host_addr = '0;
  logic [3:0]  host_wdata = '0;

  logic        cpu_ack, cpu_stall, host_ack;
  logic [3:0]  cpu_rdata, host_rdata;
  logic        ram_cs, ram_we;
  logic [11:0] ram_addr;
  logic [3:0]  ram_wdata, ram_rdata;

  logic        cpu_ack3, cpu_stall3, host_ack3;
  logic [3:0]  cpu_rdata3, host_rdata3;
  logic        ram_cs3, ram_we3;
  logic [11:0] ram_addr3;
  logic [3:0]  ram_wdata3, ram_rdata3;

`ifdef NIBBLER_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] cpu_wait_cnt, host_acc_cnt;
  logic [15:0] cpu_wait_cnt3, host_acc_cnt3;
`endif

  logic [3:0] mem [4096];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign ram_rdata  = mem[ram_addr];
  assign ram_rdata3 = ram_addr3[3:0] ^ 4'h5;

  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
  end

  nibbler_ram_arbiter #(.ACC_CYC(1)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
`ifdef NIBBLER_ARB_STATS_EN
    .stats_clr    (stats_clr),
    .cpu_wait_cnt (cpu_wait_cnt),
    .host_acc_cnt (host_acc_cnt),
`endif
    .ram_cs     (ram_cs),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  nibbler_ram_arbiter #(.ACC_CYC(3)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack3),
    .cpu_rdata  (cpu_rdata3),
    .cpu_stall  (cpu_stall3),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack3),
    .host_rdata (host_rdata3),
`ifdef NIBBLER_ARB_STATS_EN
    .stats_clr    (stats_clr),
    .cpu_wait_cnt (cpu_wait_cnt3),
    .host_acc_cnt (host_acc_cnt3),
`endif
    .ram_cs     (ram_cs3),
    .ram_we     (ram_we3),
    .ram_addr   (ram_addr3),
    .ram_wdata  (ram_wdata3),
    .ram_rdata  (ram_rdata3)
  );

  typedef struct {
    logic        creq;
    logic        cwe;
    logic [11:0] caddr;
    logic [3:0]  cwd;
    logic        hreq;
    logic        hwe;
    logic [11:0] haddr;
    logic [3:0]  hwd;
    logic [24:0] exp;
  } vec_t;

  vec_t vt [12];

  function automatic logic [24:0] ex(
    input logic cack, input logic [3:0] crd, input logic stall,
    input logic hack, input logic [3:0] hrd, input logic cs,
    input logic we, input logic [11:0] addr);
    return {cack, crd, stall, hack, hrd, cs, we, addr};
  endfunction

  function automatic vec_t mk(
    input logic creq, input logic cwe, input logic [11:0] caddr,
    input logic [3:0] cwd, input logic hreq, input logic hwe,
    input logic [11:0] haddr, input logic [3:0] hwd,
    input logic [24:0] e);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.hreq = hreq; v.hwe = hwe; v.haddr = haddr; v.hwd = hwd;
    v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [24:0] obs1();
    return {cpu_ack, cpu_rdata, cpu_stall, host_ack, host_rdata,
            ram_cs, ram_we, ram_addr};
  endfunction

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
    mem[12'h3A5] = 4'h9;

    // Table: CPU read alone, host write, CPU readback (ACC_CYC=1)
    vt[0]  = mk(0,0,12'h000,4'h0, 0,0,12'h000,4'h0,
                ex(0,4'h0,0,0,4'h0,0,0,12'h000));
    vt[1]  = mk(1,0,12'h3A5,4'h0, 0,0,12'h000,4'h0,
                ex(0,4'h0,1,0,4'h0,0,0,12'h000));
    vt[2]  = mk(1,0,12'h3A5,4'h0, 0,0,12'h000,4'h0,
                ex(0,4'h0,1,0,4'h0,1,0,12'h3A5));
    vt[3]  = mk(1,0,12'h3A5,4'h0, 0,0,12'h000,4'h0,
                ex(1,4'h9,0,0,4'h0,0,0,12'h3A5));
    vt[4]  = mk(0,0,12'h000,4'h0, 0,0,12'h000,4'h0,
                ex(0,4'h9,0,0,4'h0,0,0,12'h3A5));
    vt[5]  = mk(0,0,12'h000,4'h0, 1,1,12'h010,4'hC,
                ex(0,4'h9,0,0,4'h0,0,0,12'h3A5));
    vt[6]  = mk(0,0,12'h000,4'h0, 1,1,12'h010,4'hC,
                ex(0,4'h9,0,0,4'h0,1,1,12'h010));
    vt[7]  = mk(0,0,12'h000,4'h0, 1,1,12'h010,4'hC,
                ex(0,4'h9,0,1,4'h0,0,0,12'h010));
    vt[8]  = mk(1,0,12'h010,4'h0, 0,0,12'h000,4'h0,
                ex(0,4'h9,1,0,4'h0,0,0,12'h010));
    vt[9]  = mk(1,0,12'h010,4'h0, 0,0,12'h000,4'h0,
                ex(0,4'h9,1,0,4'h0,1,0,12'h010));
    vt[10] = mk(1,0,12'h010,4'h0, 0,0,12'h000,4'h0,
                ex(1,4'hC,0,0,4'h0,0,0,12'h010));
    vt[11] = mk(0,0,12'h000,4'h0, 0,0,12'h000,4'h0,
                ex(0,4'hC,0,0,4'h0,0,0,12'h010));

    // Reset values while reset is held
    #2;
    chk("reset_outputs", 32'(obs1()), 32'(25'd0));
    chk("reset_outputs3",
        32'({cpu_ack3, host_ack3, ram_cs3, ram_we3, ram_addr3,
             ram_wdata3, cpu_rdata3, host_rdata3}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      cpu_req = vt[i].creq; cpu_we = vt[i].cwe;
      cpu_addr = vt[i].caddr; cpu_wdata = vt[i].cwd;
      host_req = vt[i].hreq; host_we = vt[i].hwe;
      host_addr = vt[i].haddr; host_wdata = vt[i].hwd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(obs1()), 32'(vt[i].exp));
    end

    // Fairness: both requesters held from reset, strict alternation
    do_reset();
    @(posedge clk);
    #1;
    cpu_req = 1; cpu_addr = 12'h3A5;
    host_req = 1; host_addr = 12'h010;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      chk($sformatf("rr_cyc%0d", c),
          32'({cpu_ack, host_ack, cpu_stall}),
          32'({c % 6 == 2, c % 6 == 5, c % 6 != 2}));
      if (c != 17) @(posedge clk);
    end
    chk("rr_rdata", 32'({cpu_rdata, host_rdata}), 32'({4'h9, 4'hC}));

    // ACC_CYC=3: host read holds address while CPU bus changes
    do_reset();
    @(posedge clk);
    #1;
    host_req = 1; host_we = 0; host_addr = 12'h123;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) begin
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'hFFF; cpu_wdata = 4'h7;
      end
      @(negedge clk);
      chk($sformatf("hold_serve%0d", k),
          32'({ram_cs3, ram_we3, host_ack3, ram_addr3}),
          32'({1'b1, 1'b0, 1'b0, 12'h123}));
    end
    @(posedge clk);
    #1;
    host_req = 0;
    @(negedge clk);
    chk("hold_ack", 32'({host_ack3, cpu_ack3, host_rdata3}),
        32'({1'b1, 1'b0, 4'h6}));
    @(posedge clk);
    #1;
    idle_inputs();

    // Reset in second SERVE cycle of a CPU write (ACC_CYC=3)
    repeat (8) @(posedge clk);
    #1;
    chk("pre_reset_hrd3", 32'(host_rdata3), 32'h6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h055; cpu_wdata = 4'hA;
    host_req = 1; host_we = 0; host_addr = 12'h003;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_pre", 32'({ram_cs3, ram_we3, ram_addr3, ram_wdata3}),
        32'({1'b1, 1'b1, 12'h055, 4'hA}));
    #2;
    reset = 1'b1;
    #1;
    chk("abort_async", 32'({ram_cs3, ram_we3, cpu_ack3, host_ack3}),
        32'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet%0d", k),
          32'({ram_cs3, ram_we3, cpu_ack3, host_ack3,
               cpu_rdata3, host_rdata3}), 32'd0);
    end

`ifdef NIBBLER_ARB_STATS_EN
    do_reset();
    @(posedge clk);
    #1;
    host_req = 1; host_addr = 12'h010;
    @(posedge clk);
    #1;
    cpu_req = 1; cpu_addr = 12'h3A5;
    repeat (5) @(posedge clk);
    #1;
    cpu_req = 0; host_req = 0;
    @(negedge clk);
    chk("stat_wait", 32'(cpu_wait_cnt), 32'd3);
    chk("stat_host", 32'(host_acc_cnt), 32'd1);
    @(posedge clk);
    #1;
    stats_clr = 1; cpu_req = 1;
    @(posedge clk);
    #1;
    stats_clr = 0; cpu_req = 0;
    @(negedge clk);
    chk("stat_clr", 32'({cpu_wait_cnt, host_acc_cnt}), 32'd0);
    repeat (4) @(posedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nibbler_ram_arbiter.md
Name: nibbler_ram_arbiter

Overview:
- Two-requester arbiter sharing the nibbler's single-port 4Kx4 data RAM between the CPU core (requester 0) and a host/debug loader port (requester 1).
- Serialises accesses, drives the RAM's chip-select, write-enable, address and write-data, and returns registered read data with a one-cycle ack.
- Asserts cpu_stall so the core freezes PC and phase while it waits.
- Sits between the core's address_RAM/csRAM/weRAM decode outputs and the RAM array.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 4, RAM data width
ACC_CYC, 1, RAM access length in cycles, legal range 1..15

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU access request, level, held until ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  registered CPU read data
cpu_stall  out  1  cpu_req & ~cpu_ack
host_req  in  1  host access request, level
host_we  in  1  host write enable
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_ack  out  1  one-cycle completion pulse
host_rdata  out  DATA_W  registered host read data
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, combinational from ram_addr

Behaviour:
- Reset values: state IDLE, rr_last = HOST (so the CPU wins the first tie), all acks 0, ram_cs/ram_we 0, ram_addr/ram_wdata 0, cpu_rdata/host_rdata 0, serve counter 0.
- States: IDLE, SERVE, DONE.
- IDLE:
  - If any req is high, pick the owner: sole requester wins; if both are high, the requester other than rr_last wins.
  - Latch owner, we, addr and wdata into holding registers; set rr_last = owner; go to SERVE.
  - No req: stay in IDLE.
- SERVE:
  - Lasts exactly ACC_CYC cycles.
  - ram_cs = 1, ram_we = latched we; ram_addr/ram_wdata come from the holding registers and stay stable for the whole SERVE.
  - On the final SERVE edge, a read captures ram_rdata into the owner's rdata register; a write leaves rdata unchanged.
  - Then go to DONE.
- DONE:
  - Owner's ack = 1 for one cycle; ram_cs = 0; always go to IDLE.
  - The request completes at the edge where ack = 1 is sampled. req still high on the following cycle is a new request.
- Latency: req high in cycle 0 with state IDLE → SERVE in cycles 1..ACC_CYC → ack in cycle ACC_CYC+1.
- Throughput: one access per ACC_CYC+2 cycles.
- Request inputs are ignored outside IDLE. The non-owner's changing addr/we has no effect on the access in flight.
- Fairness: with both requesters continuously active, grants strictly alternate; neither waits more than one foreign access.
- req dropped before ack (protocol violation): the access still completes and ack still pulses.
- Reset mid-SERVE: ram_we/ram_cs drop asynchronously, the access is abandoned, no ack, rdata returns to 0.
- The other requester's ack and rdata are untouched by an access it does not own.

Optional Feature:
- Macro NIBBLER_ARB_STATS_EN.
- When defined, adds:
  - input stats_clr (1 bit);
  - output cpu_wait_cnt (16 bit): counts cycles with cpu_req = 1 and cpu_ack = 0 while host is the owner or the state is IDLE;
  - output host_acc_cnt (16 bit): increments on each host_ack.
- Both counters saturate at 16'hFFFF; cleared by reset or stats_clr (stats_clr has priority over increment).
- When undefined, ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package nibbler_arb_pkg holds:
  - the state enum {IDLE, SERVE, DONE};
  - requester IDs REQ_CPU = 0, REQ_HOST = 1;
  - default width constants NIB_ADDR_W = 12, NIB_DATA_W = 4.
- One sub-module, arb_rr2: a 2-way round-robin picker. It owns rr_last, takes req[1:0] and an update strobe, and outputs the grant ID.

Test Plan:
1. CPU read alone, ACC_CYC = 1, RAM[12'h3A5] = 4'h9: cpu_req at cycle 0 → ram_cs in cycle 1, cpu_ack in cycle 2, cpu_rdata = 4'h9; host_ack stays 0.
2. Host write 4'hC to 12'h010, then CPU read of 12'h010 → cpu_rdata = 4'hC; ram_we high for exactly ACC_CYC cycles.
3. Both req held high for 6 accesses from reset → grant order CPU, HOST, CPU, HOST, CPU, HOST; cpu_stall high between CPU acks.
4. ACC_CYC = 3, host read in flight, CPU changes cpu_addr mid-SERVE → ram_addr constant for 3 cycles, host_ack at cycle 4.
5. Reset asserted in the second SERVE cycle of a write → ram_we falls immediately, no ack, state IDLE, both rdata = 0.
6. With NIBBLER_ARB_STATS_EN, host continuously busy and CPU requesting → cpu_wait_cnt counts wait cycles exactly; after host_acc_cnt reaches 16'hFFFF via forced value it holds; stats_clr pulse → both 0.
